// File: rtl/csoc_test_pkg.sv
// Shared definitions for the CSoC scan engine: command opcodes, FSM states
// and the default command-length width.
package csoc_test_pkg;

  localparam int LEN_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_SHIFT   = 2'b00,
    OP_CAPTURE = 2'b01,
    OP_RESET   = 2'b10,
    OP_RUN     = 2'b11
  } csoc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } csoc_state_e;

  // Ops whose rising csoc_clk edge returns a byte to the parser.
  function automatic logic op_captures(csoc_op_e op);
    return (op == OP_SHIFT) || (op == OP_CAPTURE);
  endfunction

endpackage

// File: rtl/csoc_clk_phase.sv
// Phase timer for the CSoC scan clock: strobes phase_done on the last cycle
// of every CLK_DIV-cycle phase while enabled.
module csoc_clk_phase #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic phase_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_done = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || phase_done) cnt_d = '0;
    else if (en)           cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/csoc_scan_engine.sv
// Scan-cycle sequencer: turns opcode/length commands and scan-in bytes into
// CSoC scan clock, reset and test-control activity, returning captured bytes.
module csoc_scan_engine
  import csoc_test_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [7:0]       din_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [7:0]       dout_data,
  output logic             busy,
  output logic             done,
  output logic             csoc_clk,
  output logic             csoc_rstn,
  output logic             csoc_test_se,
  output logic             csoc_test_tm,
  output logic [7:0]       csoc_data_o,
  input  logic [7:0]       csoc_data_i,
  output csoc_state_e      dbg_state
);

  // Handshakes: a transfer happens on a clk edge where valid && ready.
  // Producers never drop valid before the transfer; din_ready is raised only
  // in LOAD, for the single cycle in which the byte is taken.

  csoc_state_e      state_q, state_d;
  csoc_op_e         op_q, op_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             rstn_q, rstn_d;
  logic             se_q, se_d;
  logic             tm_q, tm_d;
  logic [7:0]       data_o_q, data_o_d;
  logic             dout_valid_q, dout_valid_d;
  logic [7:0]       dout_data_q, dout_data_d;
  logic             cap_pend_q, cap_pend_d;

  csoc_op_e         op_in;
  logic [LEN_W-1:0] len_eff;
  logic             slot_free;
  logic             phase_en;
  logic             phase_done;

  assign op_in     = csoc_op_e'(cmd_op);
  assign len_eff   = (op_in == OP_CAPTURE && cmd_len != '0) ? LEN_W'(1) : cmd_len;
  assign slot_free = !dout_valid_q || dout_ready;
  assign phase_en  = (state_q == ST_LOW) || (state_q == ST_HIGH);

  csoc_clk_phase #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk        (clk),
    .rstn       (rstn),
    .en         (phase_en),
    .clr        (!phase_en),
    .phase_done (phase_done)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    rstn_d       = rstn_q;
    se_d         = se_q;
    tm_d         = tm_q;
    data_o_d     = data_o_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    cap_pend_d   = cap_pend_q;
    din_ready    = 1'b0;

    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
    // Sample the chip one cycle into HIGH, after its rising edge.
    if (cap_pend_q) begin
      dout_valid_d = 1'b1;
      dout_data_d  = csoc_data_i;
      cap_pend_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_in;
          cnt_d = len_eff;
          case (op_in)
            OP_SHIFT:   begin se_d = 1'b1; tm_d = 1'b1; end
            OP_CAPTURE: begin se_d = 1'b0; tm_d = 1'b1; end
            OP_RUN:     begin se_d = 1'b0; tm_d = 1'b0; end
            OP_RESET:   rstn_d = 1'b0;
            default:    ;
          endcase
          if (len_eff == '0)                        state_d = ST_DONE;
          else if (op_in == OP_SHIFT)               state_d = ST_LOAD;
          else if (op_in == OP_CAPTURE && !slot_free) state_d = ST_LOAD;
          else                                      state_d = ST_LOW;
        end
      end
      ST_LOAD: begin
        if (op_q == OP_SHIFT) begin
          if (din_valid && slot_free) begin
            din_ready = 1'b1;
            data_o_d  = din_data;
            state_d   = ST_LOW;
          end
        end else if (slot_free) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_done) begin
          state_d    = ST_HIGH;
          cap_pend_d = op_captures(op_q);
        end
      end
      ST_HIGH: begin
        if (phase_done) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1))     state_d = ST_DONE;
          else if (op_q == OP_SHIFT)  state_d = ST_LOAD;
          else                        state_d = ST_LOW;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      se_d = 1'b0;
      if (op_d == OP_RESET) rstn_d = 1'b1;
    end

    clk_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_SHIFT;
      cnt_q        <= '0;
      clk_q        <= 1'b0;
      rstn_q       <= 1'b0;
      se_q         <= 1'b0;
      tm_q         <= 1'b0;
      data_o_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      cap_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      clk_q        <= clk_d;
      rstn_q       <= rstn_d;
      se_q         <= se_d;
      tm_q         <= tm_d;
      data_o_q     <= data_o_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      cap_pend_q   <= cap_pend_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign dout_valid   = dout_valid_q;
  assign dout_data    = dout_data_q;
  assign csoc_clk     = clk_q;
  assign csoc_rstn    = rstn_q;
  assign csoc_test_se = se_q;
  assign csoc_test_tm = tm_q;
  assign csoc_data_o  = data_o_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_csoc_scan_engine.sv
// Randomised scoreboard bench for csoc_scan_engine with a looped-back or
// externally driven chip model and a command-level reference model.
module tb_csoc_scan_engine;
  import csoc_test_pkg::*;

  localparam int CD    = 2;
  localparam int LEN_W = 16;

  logic             clk, rstn;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             din_valid, din_ready;
  logic [7:0]       din_data;
  logic             dout_valid, dout_ready;
  logic [7:0]       dout_data;
  logic             busy, done;
  logic             csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic [7:0]       csoc_data_o, csoc_data_i;
  csoc_state_e      dbg_state;

  csoc_scan_engine #(.CLK_DIV(CD), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .busy(busy), .done(done),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
    .csoc_test_tm(csoc_test_tm), .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i),
    .dbg_state(dbg_state)
  );

  // Chip model: either loops scan-in back to scan-out or returns a fixed byte.
  logic       loop_mode = 1'b1;
  logic [7:0] ext_data  = 8'h00;
  assign csoc_data_i = loop_mode ? csoc_data_o : ext_data;

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] din_q[$];
  int         gap_q[$];
  logic [7:0] fix_q[$];

  logic [1:0] cur_op = OP_RUN;
  logic exp_se = 0, exp_tm = 0, exp_rstn = 0;
  logic model_tm = 0, model_rstn = 0;
  logic [7:0] model_data_o = 8'h00;
  int pulse_cnt = 0, shift_rise_cnt = 0, din_fire_cnt = 0;
  logic hold_dout = 0, bp_mode = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"},  cmd_ready, 1);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_done"},       done, 0);
    chk({tag, "_din_ready"},  din_ready, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout_data"},  dout_data, 0);
    chk({tag, "_csoc_clk"},   csoc_clk, 0);
    chk({tag, "_csoc_rstn"},  csoc_rstn, 0);
    chk({tag, "_se"},         csoc_test_se, 0);
    chk({tag, "_tm"},         csoc_test_tm, 0);
    chk({tag, "_data_o"},     csoc_data_o, 0);
  endtask

  // ---------------- drivers ----------------
  initial begin
    logic fire;
    int   gap_cnt;
    bit   gap_loaded;
    logic [7:0] junk;
    int   junk_i;
    din_valid = 0; din_data = 0; gap_cnt = 0; gap_loaded = 0;
    forever begin
      @(negedge clk);
      fire = din_valid && din_ready;
      @(posedge clk);
      #1;
      if (!rstn) begin
        din_valid = 0;
        din_q.delete();
        gap_q.delete();
        gap_loaded = 0;
      end else begin
        if (fire) begin
          junk   = din_q.pop_front();
          junk_i = gap_q.pop_front();
          din_valid = 0;
          din_fire_cnt++;
          gap_loaded = 0;
        end
        if (!din_valid && din_q.size() > 0) begin
          if (!gap_loaded) begin gap_cnt = gap_q[0]; gap_loaded = 1; end
          if (gap_cnt > 0) gap_cnt--;
          else begin din_valid = 1; din_data = din_q[0]; end
        end
      end
    end
  end

  initial begin
    dout_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = hold_dout ? 1'b0 : (bp_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- monitors ----------------
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rstn && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) fail_evt("dout_unexpected_byte");
        else begin
          exp = exp_q.pop_front();
          chk("dout_byte", dout_data, exp);
        end
      end
    end
  end

  initial begin
    logic prev;
    int hi_run, lo_run;
    prev = 0; hi_run = 0; lo_run = 1000;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev = 0; hi_run = 0; lo_run = 1000;
      end else begin
        if (csoc_clk) begin
          if (!prev) begin
            pulse_cnt++;
            chk("low_phase_min", (lo_run >= CD), 1);
            chk("se_at_rise",   csoc_test_se, exp_se);
            chk("tm_at_rise",   csoc_test_tm, exp_tm);
            chk("rstn_at_rise", csoc_rstn, exp_rstn);
            if (cur_op == OP_SHIFT) begin
              shift_rise_cnt++;
              chk("din_taken_before_rise", din_fire_cnt, shift_rise_cnt);
            end
          end
          hi_run++;
        end else begin
          if (prev) begin
            chk("high_width", hi_run, CD);
            hi_run = 0;
            lo_run = 0;
          end
          lo_run++;
        end
        prev = csoc_clk;
      end
    end
  end

  // ---------------- command driver with reference model ----------------
  task automatic run_cmd(input logic [1:0] op, input int len, input int gap_first,
                         input int gap_later, input bit chk_lat);
    int pulses, lat, p0, wait_n;
    bit got;
    logic [7:0] b;
    pulses = (op == OP_CAPTURE && len != 0) ? 1 : len;
    case (op)
      OP_SHIFT:   begin exp_se = 1; exp_tm = 1;        exp_rstn = model_rstn; end
      OP_CAPTURE: begin exp_se = 0; exp_tm = 1;        exp_rstn = model_rstn; end
      OP_RUN:     begin exp_se = 0; exp_tm = 0;        exp_rstn = model_rstn; end
      default:    begin exp_se = 0; exp_tm = model_tm; exp_rstn = 0;          end
    endcase
    cur_op = op;
    if (op == OP_SHIFT) begin
      loop_mode = 1;
      for (int i = 0; i < len; i++) begin
        b = (fix_q.size() > 0) ? fix_q.pop_front() : 8'($urandom_range(0, 255));
        din_q.push_back(b);
        gap_q.push_back(i == 0 ? gap_first : gap_later);
        exp_q.push_back(b);
        model_data_o = b;
      end
    end else if (op == OP_CAPTURE) begin
      loop_mode = 0;
      ext_data  = 8'($urandom_range(0, 255));
      if (pulses != 0) exp_q.push_back(ext_data);
    end

    @(negedge clk);
    cmd_op = op; cmd_len = LEN_W'(len); cmd_valid = 1;
    wait_n = 0;
    while (!cmd_ready && wait_n < 2000) begin @(negedge clk); wait_n++; end
    if (!cmd_ready) begin fail_evt("cmd_ready_timeout"); cmd_valid = 0; return; end
    p0 = pulse_cnt;
    @(posedge clk);
    #1 cmd_valid = 0;

    got = 0; lat = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (done) begin lat = k; got = 1; break; end
    end
    if (!got) begin fail_evt("done_timeout"); return; end

    if (chk_lat)
      chk("done_latency", lat, (op == OP_SHIFT) ? 1 + pulses * (2 * CD + 1) : 1 + pulses * 2 * CD);
    if (op != OP_RESET) model_tm = (op != OP_RUN);
    if (op == OP_RESET) model_rstn = 1;
    chk("pulse_count",    pulse_cnt - p0, pulses);
    chk("se_at_done",     csoc_test_se, 0);
    chk("tm_at_done",     csoc_test_tm, model_tm);
    chk("rstn_at_done",   csoc_rstn, model_rstn);
    chk("clk_at_done",    csoc_clk, 0);
    chk("data_o_at_done", csoc_data_o, model_data_o);
    chk("ready_at_done",  cmd_ready, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_after",    cmd_ready, 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pb, op, len, g1, g2;
    rstn = 0; cmd_valid = 0; cmd_op = 0; cmd_len = 0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rstn = 1;
    @(negedge clk);
    check_reset("post_rst");

    run_cmd(OP_RESET, 4, 0, 0, 1);
    fix_q.push_back(8'hA5); fix_q.push_back(8'h3C); fix_q.push_back(8'hFF);
    run_cmd(OP_SHIFT, 3, 0, 0, 1);
    run_cmd(OP_SHIFT, 2, 0, 10, 0);

    // Output buffer held full after the first capture.
    pb = pulse_cnt;
    hold_dout = 1;
    fork
      run_cmd(OP_SHIFT, 3, 0, 0, 0);
      begin
        repeat (30) @(negedge clk);
        chk("held_second_rise", pulse_cnt - pb, 1);
        hold_dout = 0;
      end
    join
    wait_drain();

    run_cmd(OP_CAPTURE, 5, 0, 0, 1);
    run_cmd(OP_RESET, 2, 0, 0, 1);
    run_cmd(OP_RUN, 3, 0, 0, 1);
    for (int o = 0; o < 4; o++) run_cmd(o[1:0], 0, 0, 0, 1);

    for (int i = 0; i < 30; i++) begin
      op  = $urandom_range(0, 3);
      len = $urandom_range(0, 6);
      bp_mode = 1'($urandom_range(0, 1));
      g1 = bp_mode ? $urandom_range(0, 4) : 0;
      g2 = bp_mode ? $urandom_range(0, 4) : 0;
      run_cmd(op[1:0], len, g1, g2, !bp_mode);
    end
    bp_mode = 0;
    wait_drain();

    // Asynchronous reset in the second cycle of a SHIFT.
    cur_op = OP_SHIFT; loop_mode = 1;
    for (int i = 0; i < 5; i++) begin
      din_q.push_back(8'($urandom_range(0, 255)));
      gap_q.push_back(0);
    end
    @(negedge clk);
    cmd_op = OP_SHIFT; cmd_len = 5; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(posedge clk);
    #3 rstn = 0;
    #1 check_reset("abort");
    repeat (3) @(negedge clk);
    din_fire_cnt = 0; shift_rise_cnt = 0;
    model_tm = 0; model_rstn = 0; model_data_o = 0;
    check_reset("abort_hold");
    rstn = 1;
    run_cmd(OP_SHIFT, 2, 0, 0, 1);
    run_cmd(OP_CAPTURE, 1, 0, 0, 1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    fail_evt("global_watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
